// File: rtl/gpio_bank_irq_if.sv
// gpio_bank_irq_if
//   Simple CPU bus shared by the GPIO blocks: chip select, separate write and
//   read strobes, 32-bit byte address, 32-bit write data and registered read
//   data returned by the slave one cycle after the read strobe.
//
//   master : bus decoder / CPU side (drives strobes, addr, write_data)
//   slave  : peripheral side (drives read_data)
interface gpio_bank_irq_if;
   logic        chip_select;
   logic        write_enable;
   logic        read_enable;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [31:0] read_data;

   modport master (
      output chip_select,
      output write_enable,
      output read_enable,
      output addr,
      output write_data,
      input  read_data
   );

   modport slave (
      input  chip_select,
      input  write_enable,
      input  read_enable,
      input  addr,
      input  write_data,
      output read_data
   );
endinterface

// File: rtl/gpio_bank_irq.sv
// gpio_bank_irq
//   Memory-mapped GPIO bank with input synchronisers, atomic set/clear/toggle
//   of the output data register, per-pin rising/falling edge detection with
//   write-1-to-clear status and a single registered interrupt line.
//
//   Register map (addr[5:2] decoded, other address bits ignored):
//     0x00 DATA    RW      0x14 TGL     WO  DATA ^= wd
//     0x04 DIR     RW      0x18 RISE_EN RW
//     0x08 READ    RO      0x1C FALL_EN RW
//     0x0C SET     WO      0x20 STATUS  RW1C
//     0x10 CLR     WO      0x24..0x3C reserved, read 0
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   bus       slave side of the simple CPU bus
//   gpio_in   asynchronous pin inputs
//   gpio_out  pad output data (DATA & DIR)
//   gpio_oe   pad output enables (DIR)
//   irq       level-high aggregated interrupt (registered |STATUS)
module gpio_bank_irq #(
   parameter int GPIO_WIDTH  = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   gpio_bank_irq_if.slave        bus,
   input  logic [GPIO_WIDTH-1:0] gpio_in,
   output logic [GPIO_WIDTH-1:0] gpio_out,
   output logic [GPIO_WIDTH-1:0] gpio_oe,
   output logic                  irq
);

   // Fewer than two stages cannot be trusted against metastability, so a
   // smaller setting is raised to two.
   localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   localparam logic [3:0] A_DATA    = 4'h0;
   localparam logic [3:0] A_DIR     = 4'h1;
   localparam logic [3:0] A_READ    = 4'h2;
   localparam logic [3:0] A_SET     = 4'h3;
   localparam logic [3:0] A_CLR     = 4'h4;
   localparam logic [3:0] A_TGL     = 4'h5;
   localparam logic [3:0] A_RISE_EN = 4'h6;
   localparam logic [3:0] A_FALL_EN = 4'h7;
   localparam logic [3:0] A_STATUS  = 4'h8;

   logic [GPIO_WIDTH-1:0] data_q,    data_d;
   logic [GPIO_WIDTH-1:0] dir_q,     dir_d;
   logic [GPIO_WIDTH-1:0] rise_en_q, rise_en_d;
   logic [GPIO_WIDTH-1:0] fall_en_q, fall_en_d;
   logic [GPIO_WIDTH-1:0] status_q,  status_d;
   logic [GPIO_WIDTH-1:0] prev_q;
   logic [GPIO_WIDTH-1:0] sync_q [STAGES];
   logic [31:0]           read_data_q, read_data_d;
   logic                  irq_q;

   logic                  wr_en;
   logic                  rd_en;
   logic [3:0]            sel;
   logic [GPIO_WIDTH-1:0] wd;
   logic [GPIO_WIDTH-1:0] sync_in;
   logic [GPIO_WIDTH-1:0] read_val;
   logic [GPIO_WIDTH-1:0] rise;
   logic [GPIO_WIDTH-1:0] fall;
   logic [GPIO_WIDTH-1:0] w1c;

   // Address bits outside [5:2] and write data above GPIO_WIDTH are don't-care.
   logic                  unused_bus_bits;
   assign unused_bus_bits = ^{bus.addr[31:6], bus.addr[1:0], bus.write_data};

   assign wr_en   = bus.chip_select & bus.write_enable;
   assign rd_en   = bus.chip_select & bus.read_enable;
   assign sel     = bus.addr[5:2];
   assign wd      = bus.write_data[GPIO_WIDTH-1:0];
   assign sync_in = sync_q[STAGES-1];

   assign read_val = (data_q & dir_q) | (sync_in & ~dir_q);

   // Output pins are masked out, and prev_q always follows sync_in, so a
   // direction change alone can never look like an edge.
   assign rise = sync_in  & ~prev_q & ~dir_q & rise_en_q;
   assign fall = ~sync_in &  prev_q & ~dir_q & fall_en_q;

   assign w1c = (wr_en && (sel == A_STATUS)) ? wd : '0;

   always_comb begin
      data_d    = data_q;
      dir_d     = dir_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      if (wr_en) begin
         case (sel)
            A_DATA:    data_d    = wd;
            A_DIR:     dir_d     = wd;
            A_SET:     data_d    = data_q | wd;
            A_CLR:     data_d    = data_q & ~wd;
            A_TGL:     data_d    = data_q ^ wd;
            A_RISE_EN: rise_en_d = wd;
            A_FALL_EN: fall_en_d = wd;
            default:   ;
         endcase
      end
   end

   // Clear first, then OR in new events: an event coinciding with its own
   // W1C keeps the bit set so it is not lost.
   always_comb begin
      status_d = (status_q & ~w1c) | rise | fall;
   end

   // Read mux uses the pre-edge register values, so a read colliding with a
   // write to the same register returns the old contents.
   always_comb begin
      read_data_d = read_data_q;
      if (rd_en) begin
         read_data_d = '0;
         case (sel)
            A_DATA:    read_data_d[GPIO_WIDTH-1:0] = data_q;
            A_DIR:     read_data_d[GPIO_WIDTH-1:0] = dir_q;
            A_READ:    read_data_d[GPIO_WIDTH-1:0] = read_val;
            A_RISE_EN: read_data_d[GPIO_WIDTH-1:0] = rise_en_q;
            A_FALL_EN: read_data_d[GPIO_WIDTH-1:0] = fall_en_q;
            A_STATUS:  read_data_d[GPIO_WIDTH-1:0] = status_q;
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= gpio_in;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q      <= '0;
         dir_q       <= '0;
         rise_en_q   <= '0;
         fall_en_q   <= '0;
         status_q    <= '0;
         prev_q      <= '0;
         read_data_q <= '0;
         irq_q       <= 1'b0;
      end else begin
         data_q      <= data_d;
         dir_q       <= dir_d;
         rise_en_q   <= rise_en_d;
         fall_en_q   <= fall_en_d;
         status_q    <= status_d;
         prev_q      <= sync_in;
         read_data_q <= read_data_d;
         irq_q       <= |status_q;
      end
   end

   assign gpio_out      = data_q & dir_q;
   assign gpio_oe       = dir_q;
   assign irq           = irq_q;
   assign bus.read_data = read_data_q;

endmodule

// File: tb/tb_gpio_bank_irq.sv
module tb_gpio_bank_irq;

   logic        clk;
   logic        rst;
   logic [31:0] gpio_in;
   logic [31:0] gpio_out;
   logic [31:0] gpio_oe;
   logic        irq;
   logic [7:0]  gpio_in8;
   logic [7:0]  gpio_out8;
   logic [7:0]  gpio_oe8;
   logic        irq8;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];
   bit          b8_q[$];

   gpio_bank_irq_if bus ();
   gpio_bank_irq_if bus8 ();

   gpio_bank_irq #(.GPIO_WIDTH(32), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .gpio_oe  (gpio_oe),
      .irq      (irq)
   );

   gpio_bank_irq #(.GPIO_WIDTH(8), .SYNC_STAGES(2)) dut8 (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus8),
      .gpio_in  (gpio_in8),
      .gpio_out (gpio_out8),
      .gpio_oe  (gpio_oe8),
      .irq      (irq8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit b8, input logic cs, input logic we, input logic re,
                        input logic [31:0] a, input logic [31:0] wd);
      if (b8) begin
         bus8.chip_select = cs; bus8.write_enable = we; bus8.read_enable = re;
         bus8.addr = a; bus8.write_data = wd;
      end else begin
         bus.chip_select = cs; bus.write_enable = we; bus.read_enable = re;
         bus.addr = a; bus.write_data = wd;
      end
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic pop_check();
      logic [31:0] e;
      string       t;
      bit          b;
      logic [31:0] obs;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      b = b8_q.pop_front();
      obs = b ? bus8.read_data : bus.read_data;
      chk(t, obs, e);
   endtask

   task automatic wr(input bit b8, input logic [5:0] a, input logic [31:0] wd);
      drive(b8, 1'b1, 1'b1, 1'b0, {26'h0, a}, wd);
      tick();
      idle();
   endtask

   task automatic rd(input bit b8, input logic [5:0] a, input logic [31:0] exp, input string tag);
      drive(b8, 1'b1, 1'b0, 1'b1, {26'h0, a}, 32'h0);
      exp_q.push_back(exp); tag_q.push_back(tag); b8_q.push_back(b8);
      tick();
      idle();
      pop_check();
   endtask

   task automatic rdwr(input logic [5:0] a, input logic [31:0] wd, input logic [31:0] exp,
                       input string tag);
      drive(1'b0, 1'b1, 1'b1, 1'b1, {26'h0, a}, wd);
      exp_q.push_back(exp); tag_q.push_back(tag); b8_q.push_back(1'b0);
      tick();
      idle();
      pop_check();
   endtask

   initial begin
      rst = 1'b1;
      gpio_in = 32'h0;
      gpio_in8 = 8'h0;
      idle();
      ticks(2);
      chk("rst_gpio_out", gpio_out, 32'h0);
      chk("rst_gpio_oe",  gpio_oe,  32'h0);
      chk("rst_irq",      {31'h0, irq}, 32'h0);
      chk("rst_rdata",    bus.read_data, 32'h0);
      rst = 1'b0;
      tick();
      rd(0, 6'h00, 32'h0, "rst_data");

      // Basic RW and READ with all pins as outputs
      wr(0, 6'h04, 32'hFFFF_FFFF);
      wr(0, 6'h00, 32'h1234_5678);
      chk("gpio_out_all", gpio_out, 32'h1234_5678);
      rd(0, 6'h00, 32'h1234_5678, "data_rd");
      rd(0, 6'h04, 32'hFFFF_FFFF, "dir_rd");
      rd(0, 6'h08, 32'h1234_5678, "read_rd");

      // Atomic set/clear/toggle
      wr(0, 6'h0C, 32'h0000_00F0);
      wr(0, 6'h10, 32'h0000_0008);
      wr(0, 6'h14, 32'h8000_0001);
      rd(0, 6'h00, 32'h9234_56F1, "sct_data");
      rd(0, 6'h0C, 32'h0, "wo_set_rd0");
      rd(0, 6'h24, 32'h0, "reserved_rd0");

      // Read colliding with write returns the old value
      rdwr(6'h00, 32'h0, 32'h9234_56F1, "rw_same_old");
      rd(0, 6'h00, 32'h0, "rw_same_new");

      // Mixed direction
      wr(0, 6'h04, 32'hFFFF_0000);
      wr(0, 6'h00, 32'hABCD_EF00);
      gpio_in = 32'h0000_DEAD;
      ticks(2);
      rd(0, 6'h08, 32'hABCD_DEAD, "mixed_read");
      chk("mixed_out", gpio_out, 32'hABCD_0000);
      chk("mixed_oe",  gpio_oe,  32'hFFFF_0000);

      // Rising edge on pin 0
      wr(0, 6'h04, 32'h0);
      gpio_in = 32'h0;
      ticks(4);
      wr(0, 6'h18, 32'h1);
      gpio_in = 32'h1;
      ticks(2);
      rd(0, 6'h20, 32'h0, "rise_stat_early");
      chk("rise_irq_early", {31'h0, irq}, 32'h0);
      rd(0, 6'h20, 32'h1, "rise_stat");
      chk("rise_irq", {31'h0, irq}, 32'h1);
      wr(0, 6'h20, 32'h1);
      chk("w1c_irq_lag", {31'h0, irq}, 32'h1);
      tick();
      chk("w1c_irq_drop", {31'h0, irq}, 32'h0);
      rd(0, 6'h20, 32'h0, "w1c_stat");

      // Falling edge on pin 1 colliding with its own W1C: set wins
      gpio_in = 32'h3;
      ticks(4);
      wr(0, 6'h1C, 32'h2);
      gpio_in = 32'h1;
      ticks(2);
      wr(0, 6'h20, 32'h2);
      rd(0, 6'h20, 32'h2, "setwins_stat");
      chk("setwins_irq", {31'h0, irq}, 32'h1);
      wr(0, 6'h20, 32'h0);
      rd(0, 6'h20, 32'h2, "w0_noeffect");
      wr(0, 6'h20, 32'h2);
      ticks(2);
      chk("fall_clr_irq", {31'h0, irq}, 32'h0);

      // Output pins never raise events; direction change is not an edge
      wr(0, 6'h18, 32'h3);
      wr(0, 6'h04, 32'h2);
      gpio_in = 32'h3; ticks(4);
      gpio_in = 32'h1; ticks(4);
      gpio_in = 32'h3; ticks(4);
      wr(0, 6'h04, 32'h0);
      ticks(4);
      rd(0, 6'h20, 32'h0, "outpin_no_evt");
      chk("outpin_irq", {31'h0, irq}, 32'h0);

      // Latch STATUS=0x3, then disabling enables keeps it
      gpio_in = 32'h2; ticks(4);
      gpio_in = 32'h3; ticks(4);
      gpio_in = 32'h1; ticks(4);
      wr(0, 6'h18, 32'h0);
      wr(0, 6'h1C, 32'h0);
      rd(0, 6'h20, 32'h3, "en_off_keep");
      wr(0, 6'h04, 32'hFFFF_0000);
      chk("pre_rst_out", gpio_out, 32'hABCD_0000);
      chk("pre_rst_irq", {31'h0, irq}, 32'h1);

      // Reset mid-transaction
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF);
      rst = 1'b1;
      gpio_in = 32'h0;
      tick();
      chk("mid_rst_out",   gpio_out, 32'h0);
      chk("mid_rst_oe",    gpio_oe,  32'h0);
      chk("mid_rst_irq",   {31'h0, irq}, 32'h0);
      chk("mid_rst_rdata", bus.read_data, 32'h0);
      rst = 1'b0;
      idle();
      for (int a = 0; a <= 8; a++) begin
         rd(0, 6'(a * 4), 32'h0, $sformatf("post_rst_reg%0d", a));
      end

      // Narrow instance: bits above GPIO_WIDTH read 0
      wr(1, 6'h04, 32'hFFFF_FFFF);
      wr(1, 6'h00, 32'hFFFF_FFFF);
      rd(1, 6'h00, 32'h0000_00FF, "w8_data");
      rd(1, 6'h04, 32'h0000_00FF, "w8_dir");
      rd(1, 6'h08, 32'h0000_00FF, "w8_read");
      chk("w8_out", {24'h0, gpio_out8}, 32'h0000_00FF);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gpio_bank_irq.md
Name: gpio_bank_irq

Overview:
- Parametrised next-generation memory-mapped GPIO bank on the same simple bus as the existing GPIO controller: chip_select, write_enable, read_enable, 32-bit addr and data.
- Adds:
  - configurable pin count;
  - input synchronisers;
  - atomic set/clear/toggle of output data;
  - per-pin rising/falling edge interrupts with write-1-to-clear status and a single aggregated interrupt line.
- Sits beside the CPU bus decoder and drives pads and the interrupt controller.

Parameters:
- GPIO_WIDTH, 32, number of pins (1..32); register bits at and above GPIO_WIDTH read 0 and ignore writes.
- SYNC_STAGES, 2, depth of the flop synchroniser on gpio_in (minimum 2).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  32  byte address; only addr[5:2] decoded, other bits ignored.
- write_data  input  32  bus write data.
- read_data  output  32  registered bus read data.
- write_enable  input  1  write strobe, qualified by chip_select.
- read_enable  input  1  read strobe, qualified by chip_select.
- chip_select  input  1  block select.
- gpio_in  input  GPIO_WIDTH  asynchronous external pin inputs.
- gpio_out  output  GPIO_WIDTH  pad outputs.
- gpio_oe  output  GPIO_WIDTH  pad output enables (equals DIR).
- irq  output  1  aggregated interrupt, level high.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. All state clears to 0 on the rising edge of clk with rst=1, including mid-transaction: every register, synchroniser flops, previous-input flop, read_data, irq. Reset outputs: gpio_out=0, gpio_oe=0, read_data=0, irq=0.
- Register map (offset = addr[5:0]):
  - 0x00 DATA RW
  - 0x04 DIR RW, 1=output
  - 0x08 READ RO
  - 0x0C SET WO: DATA |= wd
  - 0x10 CLR WO: DATA &= ~wd
  - 0x14 TGL WO: DATA ^= wd
  - 0x18 RISE_EN RW
  - 0x1C FALL_EN RW
  - 0x20 STATUS RW1C
  - 0x24..0x3C reserved: read 0, writes ignored.
  - WO registers read 0.
- Write: when chip_select && write_enable at a clk edge, the target register updates at that edge. The new value is visible on gpio_out/gpio_oe in the same cycle after the edge.
- Read: when chip_select && read_enable at a clk edge, read_data captures the addressed value at that edge (1-cycle latency). Otherwise read_data holds its last value. A read in the same cycle as a write to the same register returns the pre-write value.
- Simultaneous write_enable and read_enable: both performed per the rules above.
- gpio_out = DATA & DIR; gpio_oe = DIR.
- Synchroniser: gpio_in passes through SYNC_STAGES flops, giving sync_in.
- READ value = (DATA & DIR) | (sync_in & ~DIR). An external change appears in READ SYNC_STAGES cycles later, captured by the next read.
- Edge detection:
  - prev_in register holds sync_in from the previous cycle.
  - rise = sync_in & ~prev_in & ~DIR & RISE_EN.
  - fall = ~sync_in & prev_in & ~DIR & FALL_EN.
  - Output pins never raise events.
- STATUS[i]: set on rise[i]|fall[i]; cleared by writing 1 to bit i at 0x20. A set event in the same cycle as a W1C on the same bit leaves the bit set (set wins). Writing 0 has no effect.
- Enables: disabling RISE_EN/FALL_EN does not clear already-latched STATUS.
- irq = |STATUS, registered: it asserts the cycle after the STATUS bit sets and drops the cycle after the W1C clears the last bit.
- Direction change: switching a pin from output to input does not generate a spurious edge by itself. Only sync_in transitions do.
- Width: write_data[31:GPIO_WIDTH] is ignored; reads are zero-extended to 32 bits.

Test Plan:
- Reset, then write DIR=0xFFFFFFFF and DATA=0x12345678. Reads of 0x00, 0x04 and 0x08 return 0x12345678, 0xFFFFFFFF and 0x12345678 one cycle after the read strobe. gpio_out=0x12345678.
- Write SET=0x000000F0, then CLR=0x00000008, then TGL=0x80000001. DATA reads 0x923456F1 (from 0x12345678 → 0x123456F8 → 0x123456F0 → 0x923456F1).
- DIR=0xFFFF0000, DATA=0xABCDEF00, gpio_in=0x0000DEAD. After 2 cycles, READ returns 0xABCDDEAD, gpio_out=0xABCD0000 and gpio_oe=0xFFFF0000.
- DIR=0, RISE_EN=0x1, gpio_in[0] 0→1. STATUS=0x1 on cycle 3 after the change and irq=1 the following cycle. Writing STATUS=0x1 clears it, and irq=0 the next cycle.
- FALL_EN=0x2: drop gpio_in[1] and time the W1C to coincide with the fall event. STATUS[1] stays 1. gpio_in[1] toggling while DIR[1]=1 never sets STATUS.
- Assert rst mid-sequence with STATUS=0x3 and DATA nonzero. On the next edge all outputs are 0 and every register reads 0. Re-run with GPIO_WIDTH=8: a write of DATA=0xFFFFFFFF reads back 0x000000FF.
